// File: rtl/scmp_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// scmp_arb_pak -- shared definitions for the SCMP two-port bus arbiter.
//   * arb_state_e   : arbiter FSM state encoding
//   * OWN_CPU/OWN_DMA : port index values carried on 'owner'
//   * WAIT_MIN_LO/HI  : legal range of the WAIT_MIN strobe-length parameter
//   * strb_load()     : strobe counter load value for a given WAIT_MIN
// -----------------------------------------------------------------------------
package scmp_arb_pak;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_STRB = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int WAIT_MIN_LO = 1;
  localparam int WAIT_MIN_HI = 15;

  // The counter is loaded with WAIT_MIN-1 so that a zero count means the
  // minimum strobe length has been served. Out-of-range values are clamped
  // so the 4-bit counter can never be loaded with a wrapped value.
  function automatic logic [3:0] strb_load(input int wait_min);
    int w;
    if (wait_min < WAIT_MIN_LO)      w = WAIT_MIN_LO;
    else if (wait_min > WAIT_MIN_HI) w = WAIT_MIN_HI;
    else                             w = wait_min;
    return 4'(w - 1);
  endfunction

endpackage

// File: rtl/scmp_bus_arb_if.sv
// -----------------------------------------------------------------------------
// scmp_bus_arb_if -- bundle of the arbiter's request ports and memory bus.
//   CPU port : cpu_req, cpu_we, cpu_addr[11:0], cpu_wdata[7:0] -> cpu_ack
//   DMA port : dma_req, dma_we, dma_addr[11:0], dma_wdata[7:0] -> dma_ack
//   Shared   : rdata[7:0] (last read data), owner (0=CPU, 1=DMA)
//   Memory   : mem_addr[11:0], mem_d_o[7:0], mem_ads_n, mem_rd_n, mem_wr_n
//              out; mem_d_i[7:0], mem_hold in
// Modports:
//   master : the arbiter's view (it masters the memory bus)
//   slave  : the environment's view (requesters plus memory device)
// -----------------------------------------------------------------------------
interface scmp_bus_arb_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;

  logic        dma_req;
  logic        dma_we;
  logic [11:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;

  logic [7:0]  rdata;
  logic        owner;

  logic [11:0] mem_addr;
  logic [7:0]  mem_d_o;
  logic [7:0]  mem_d_i;
  logic        mem_ads_n;
  logic        mem_rd_n;
  logic        mem_wr_n;
  logic        mem_hold;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_d_i, mem_hold,
    output cpu_ack, dma_ack, rdata, owner,
    output mem_addr, mem_d_o, mem_ads_n, mem_rd_n, mem_wr_n
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_d_i, mem_hold,
    input  cpu_ack, dma_ack, rdata, owner,
    input  mem_addr, mem_d_o, mem_ads_n, mem_rd_n, mem_wr_n
  );

endinterface

// File: rtl/scmp_bus_arb_pick.sv
// -----------------------------------------------------------------------------
// scmp_arb_pick -- combinational grant select for the two request ports.
// Optional feature macro: SCMP_ARB_RR_EN (round-robin tie-break).
// Ports:
//   i_cpu_req, i_dma_req : current requests
//   i_last_grant         : port granted last (only with SCMP_ARB_RR_EN)
//   o_any                : at least one request is pending
//   o_grant              : selected port (OWN_CPU / OWN_DMA)
// A single requester always wins; on a tie the CPU wins, or with
// SCMP_ARB_RR_EN the port not granted last wins.
// -----------------------------------------------------------------------------
module scmp_arb_pick
  import scmp_arb_pak::*;
(
  input  logic i_cpu_req,
  input  logic i_dma_req,
`ifdef SCMP_ARB_RR_EN
  input  logic i_last_grant,
`endif
  output logic o_any,
  output logic o_grant
);

  assign o_any = i_cpu_req | i_dma_req;

  always_comb begin
    // NOTE: assigning a default before any branch keeps this purely
    // combinational; a path that leaves o_grant unassigned would infer a latch.
    o_grant = OWN_CPU;
    if (i_cpu_req && i_dma_req) begin
`ifdef SCMP_ARB_RR_EN
      o_grant = ~i_last_grant;
`else
      o_grant = OWN_CPU;
`endif
    end else if (i_dma_req) begin
      o_grant = OWN_DMA;
    end
  end

endmodule

// File: rtl/scmp_bus_arb.sv
// -----------------------------------------------------------------------------
// scmp_bus_arb -- arbitrates a CPU port and a DMA port onto one external
// strobed memory bus, one transaction at a time (IDLE -> ADDR -> STRB -> DONE).
// Optional feature macro: SCMP_ARB_RR_EN (round-robin tie-break, adds a
// last-grant register; otherwise the CPU always wins ties).
// Parameters:
//   WAIT_MIN : minimum strobe length in clocks (1..15)
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : scmp_bus_arb_if.master (request ports, shared results, memory bus)
// All bus outputs are registered.
// -----------------------------------------------------------------------------
module scmp_bus_arb #(
  parameter int WAIT_MIN = 1
) (
  input logic            clk,
  input logic            rst_n,
  scmp_bus_arb_if.master bus
);
  import scmp_arb_pak::*;

  localparam logic [3:0] LP_STRB_LOAD = strb_load(WAIT_MIN);

  arb_state_e  r_state;
  logic        r_we;
  logic [3:0]  r_cnt;
  logic        r_ads_n;
  logic        r_rd_n;
  logic        r_wr_n;
  logic        r_cpu_ack;
  logic        r_dma_ack;
  logic [7:0]  r_rdata;
  logic        r_owner;
  logic [11:0] r_mem_addr;  // doubles as the latched request address
  logic [7:0]  r_mem_d_o;   // doubles as the latched write data
`ifdef SCMP_ARB_RR_EN
  logic        r_last_grant;
`endif

  logic        w_any;
  logic        w_grant;

  scmp_arb_pick u_pick (
    .i_cpu_req    (bus.cpu_req),
    .i_dma_req    (bus.dma_req),
`ifdef SCMP_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_any        (w_any),
    .o_grant      (w_grant)
  );

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_cnt        <= 4'd0;
      r_ads_n      <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_rdata      <= 8'h00;
      r_owner      <= OWN_CPU;
      r_mem_addr   <= 12'h000;
      r_mem_d_o    <= 8'h00;
`ifdef SCMP_ARB_RR_EN
      r_last_grant <= OWN_DMA;  // so the CPU wins the first tie
`endif
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_grant;
`ifdef SCMP_ARB_RR_EN
            r_last_grant <= w_grant;
`endif
            if (w_grant == OWN_DMA) begin
              r_we       <= bus.dma_we;
              r_mem_addr <= bus.dma_addr;
              r_mem_d_o  <= bus.dma_we ? bus.dma_wdata : 8'h00;
            end else begin
              r_we       <= bus.cpu_we;
              r_mem_addr <= bus.cpu_addr;
              r_mem_d_o  <= bus.cpu_we ? bus.cpu_wdata : 8'h00;
            end
            r_ads_n <= 1'b0;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          r_ads_n <= 1'b1;
          r_rd_n  <= r_we;
          r_wr_n  <= ~r_we;
          r_cnt   <= LP_STRB_LOAD;
          r_state <= ST_STRB;
        end
        ST_STRB: begin
          // mem_hold only matters once the minimum length has been served.
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!bus.mem_hold) begin
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            if (!r_we) r_rdata <= bus.mem_d_i;
            r_cpu_ack <= (r_owner == OWN_CPU);
            r_dma_ack <= (r_owner == OWN_DMA);
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_mem_addr <= 12'h000;
          r_mem_d_o  <= 8'h00;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.rdata     = r_rdata;
  assign bus.owner     = r_owner;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_d_o   = r_mem_d_o;
  assign bus.mem_ads_n = r_ads_n;
  assign bus.mem_rd_n  = r_rd_n;
  assign bus.mem_wr_n  = r_wr_n;

endmodule

// File: tb/tb_scmp_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_scmp_bus_arb -- self-checking bench for scmp_bus_arb.
// Two instances share one stimulus: u_dut_a (WAIT_MIN=1) and u_dut_b
// (WAIT_MIN=4). Expected transactions are pushed to a scoreboard queue when
// requests are driven and popped when the DUT acknowledges.
// -----------------------------------------------------------------------------
module tb_scmp_bus_arb;
  import scmp_arb_pak::*;

  localparam int BUDGET = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scmp_bus_arb_if bus_a ();
  scmp_bus_arb_if bus_b ();

  assign bus_b.cpu_req   = bus_a.cpu_req;
  assign bus_b.cpu_we    = bus_a.cpu_we;
  assign bus_b.cpu_addr  = bus_a.cpu_addr;
  assign bus_b.cpu_wdata = bus_a.cpu_wdata;
  assign bus_b.dma_req   = bus_a.dma_req;
  assign bus_b.dma_we    = bus_a.dma_we;
  assign bus_b.dma_addr  = bus_a.dma_addr;
  assign bus_b.dma_wdata = bus_a.dma_wdata;
  assign bus_b.mem_d_i   = bus_a.mem_d_i;
  assign bus_b.mem_hold  = bus_a.mem_hold;

  scmp_bus_arb #(.WAIT_MIN(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  scmp_bus_arb #(.WAIT_MIN(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic        owner;
    logic [11:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } exp_t;

  typedef struct {
    int          ads_cyc;
    int          strb_cnt;
    int          ack_cyc;
    logic        owner;
    logic [11:0] addr;
    logic        addr_stable;
    logic [7:0]  dout;
    logic [7:0]  rdata;
    logic        other_ack;
    logic        ok;
  } obs_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_rdata_a = 8'h00;  // model of u_dut_a's rdata

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Follow one transaction on the selected DUT until its ack, sampling on
  // falling edges and driving mem_hold for the first hold_n strobe clocks.
  task automatic observe(input bit sel_b, input int hold_n, input bit keep_req,
                         input bit alter_at_ads, output obs_t o);
    int k;
    logic ads_n, rd_n, wr_n, cack, dack, own;
    logic [11:0] ma;
    logic [7:0] md, rd;
    o = '{default: 0};
    o.ads_cyc = -1;
    k = 0;
    while (k < BUDGET) begin
      @(negedge clk);
      k++;
      ads_n = sel_b ? bus_b.mem_ads_n : bus_a.mem_ads_n;
      rd_n  = sel_b ? bus_b.mem_rd_n  : bus_a.mem_rd_n;
      wr_n  = sel_b ? bus_b.mem_wr_n  : bus_a.mem_wr_n;
      cack  = sel_b ? bus_b.cpu_ack   : bus_a.cpu_ack;
      dack  = sel_b ? bus_b.dma_ack   : bus_a.dma_ack;
      own   = sel_b ? bus_b.owner     : bus_a.owner;
      ma    = sel_b ? bus_b.mem_addr  : bus_a.mem_addr;
      md    = sel_b ? bus_b.mem_d_o   : bus_a.mem_d_o;
      rd    = sel_b ? bus_b.rdata     : bus_a.rdata;
      if (!ads_n) begin
        o.ads_cyc = k;
        o.addr = ma;
        o.addr_stable = 1'b1;
        if (!keep_req) begin
          bus_a.cpu_req = 1'b0;
          bus_a.dma_req = 1'b0;
        end
        if (alter_at_ads) begin
          bus_a.cpu_addr  = 12'h0F0;
          bus_a.cpu_wdata = 8'hFF;
        end
      end else if (o.ads_cyc > 0 && ma !== o.addr) begin
        o.addr_stable = 1'b0;
      end
      if (!rd_n || !wr_n) begin
        o.strb_cnt++;
        bus_a.mem_hold = (o.strb_cnt <= hold_n);
      end else begin
        bus_a.mem_hold = 1'b0;
      end
      if (cack || dack) begin
        o.ack_cyc   = k;
        o.owner     = own;
        o.rdata     = rd;
        o.dout      = md;
        o.other_ack = own ? cack : dack;
        o.ok        = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!o.ok) begin
      n_errors++;
      $display("FAIL ack_timeout: no ack within %0d cycles (required an ack)", BUDGET);
    end
  endtask

  task automatic test_reset();
    bus_a.cpu_req = 0; bus_a.cpu_we = 0; bus_a.cpu_addr = 0; bus_a.cpu_wdata = 0;
    bus_a.dma_req = 0; bus_a.dma_we = 0; bus_a.dma_addr = 0; bus_a.dma_wdata = 0;
    bus_a.mem_d_i = 0; bus_a.mem_hold = 0;
    rst_n = 1'b0;
    idle(3);
    n_checks++;
    if ({bus_a.mem_ads_n, bus_a.mem_rd_n, bus_a.mem_wr_n, bus_a.cpu_ack, bus_a.dma_ack} !== 5'b11100) begin
      n_errors++;
      $display("FAIL reset_strobes: ads/rd/wr/cack/dack=%b required 11100",
               {bus_a.mem_ads_n, bus_a.mem_rd_n, bus_a.mem_wr_n, bus_a.cpu_ack, bus_a.dma_ack});
    end
    n_checks++;
    if (bus_a.rdata !== 8'h00) begin
      n_errors++; $display("FAIL reset_rdata: got %h required 00", bus_a.rdata);
    end
    n_checks++;
    if (bus_a.owner !== OWN_CPU) begin
      n_errors++; $display("FAIL reset_owner: got %b required 0", bus_a.owner);
    end
    n_checks++;
    if ({bus_a.mem_addr, bus_a.mem_d_o} !== 20'h0) begin
      n_errors++; $display("FAIL reset_bus: addr=%h d_o=%h required 000/00", bus_a.mem_addr, bus_a.mem_d_o);
    end
    rst_n = 1'b1;
    idle(2);
    m_rdata_a = 8'h00;
  endtask

  task automatic test_cpu_read();
    obs_t o; exp_t e;
    bus_a.mem_d_i = 8'h5A;
    bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 12'h123;
    sb_q.push_back('{OWN_CPU, 12'h123, 1'b0, 8'h00, 8'h5A});
    m_rdata_a = 8'h5A;
    observe(1'b0, 0, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_checks++;
    if (o.ads_cyc != 1 || o.strb_cnt != 1 || o.ack_cyc != 3) begin
      n_errors++;
      $display("FAIL cpu_read_timing: ads=%0d strb=%0d ack=%0d required 1/1/3", o.ads_cyc, o.strb_cnt, o.ack_cyc);
    end
    n_checks++;
    if (o.addr !== e.addr || !o.addr_stable) begin
      n_errors++; $display("FAIL cpu_read_addr: got %h stable=%b required %h", o.addr, o.addr_stable, e.addr);
    end
    n_checks++;
    if (o.owner !== e.owner || o.other_ack !== 1'b0) begin
      n_errors++; $display("FAIL cpu_read_owner: owner=%b other_ack=%b required %b/0", o.owner, o.other_ack, e.owner);
    end
    n_checks++;
    if (o.rdata !== e.rdata || o.dout !== 8'h00) begin
      n_errors++; $display("FAIL cpu_read_data: rdata=%h d_o=%h required %h/00", o.rdata, o.dout, e.rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus_a.cpu_ack !== 1'b0 || bus_a.mem_addr !== 12'h000) begin
      n_errors++; $display("FAIL cpu_read_idle: ack=%b addr=%h required 0/000", bus_a.cpu_ack, bus_a.mem_addr);
    end
    idle(8);
  endtask

  task automatic test_dma_write_hold();
    obs_t o; exp_t e;
    bus_a.mem_d_i = 8'hEE;
    bus_a.dma_req = 1; bus_a.dma_we = 1; bus_a.dma_addr = 12'hFFF; bus_a.dma_wdata = 8'hA5;
    sb_q.push_back('{OWN_DMA, 12'hFFF, 1'b1, 8'hA5, m_rdata_a});
    observe(1'b0, 3, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_checks++;
    if (o.strb_cnt != 4 || o.ack_cyc != 6) begin
      n_errors++; $display("FAIL dma_write_strobe: strb=%0d ack=%0d required 4/6", o.strb_cnt, o.ack_cyc);
    end
    n_checks++;
    if (o.dout !== e.wdata || o.addr !== e.addr || !o.addr_stable) begin
      n_errors++;
      $display("FAIL dma_write_bus: d_o=%h addr=%h stable=%b required %h/%h/1", o.dout, o.addr, o.addr_stable, e.wdata, e.addr);
    end
    n_checks++;
    if (o.owner !== e.owner || o.other_ack !== 1'b0) begin
      n_errors++; $display("FAIL dma_write_owner: owner=%b cpu_ack=%b required %b/0", o.owner, o.other_ack, e.owner);
    end
    n_checks++;
    if (o.rdata !== e.rdata) begin
      n_errors++; $display("FAIL dma_write_rdata: got %h required %h", o.rdata, e.rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus_a.dma_ack !== 1'b0 || bus_a.mem_d_o !== 8'h00) begin
      n_errors++; $display("FAIL dma_write_once: ack=%b d_o=%h required 0/00", bus_a.dma_ack, bus_a.mem_d_o);
    end
    idle(8);
  endtask

  task automatic test_mid_change();
    obs_t o; exp_t e;
    bus_a.mem_d_i = 8'h81;
    bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 12'h2C4;
    sb_q.push_back('{OWN_CPU, 12'h2C4, 1'b0, 8'h00, 8'h81});
    m_rdata_a = 8'h81;
    observe(1'b0, 0, 1'b0, 1'b1, o);
    e = sb_q.pop_front();
    n_checks++;
    if (o.addr !== e.addr || !o.addr_stable) begin
      n_errors++; $display("FAIL mid_change_addr: got %h stable=%b required %h", o.addr, o.addr_stable, e.addr);
    end
    n_checks++;
    if (o.ack_cyc != 3 || o.owner !== e.owner || o.rdata !== e.rdata) begin
      n_errors++;
      $display("FAIL mid_change_ack: ack=%0d owner=%b rdata=%h required 3/%b/%h", o.ack_cyc, o.owner, o.rdata, e.owner, e.rdata);
    end
    idle(8);
  endtask

  task automatic test_back_to_back_tie();
    obs_t o; exp_t e;
    logic exp_own [4];
`ifdef SCMP_ARB_RR_EN
    exp_own = '{OWN_CPU, OWN_DMA, OWN_CPU, OWN_DMA};
`else
    exp_own = '{OWN_CPU, OWN_CPU, OWN_CPU, OWN_CPU};
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rdata_a = 8'h00;
    bus_a.mem_d_i = 8'h77;
    bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 12'h111;
    bus_a.dma_req = 1; bus_a.dma_we = 0; bus_a.dma_addr = 12'h222;
    for (int i = 0; i < 4; i++)
      sb_q.push_back('{exp_own[i], exp_own[i] ? 12'h222 : 12'h111, 1'b0, 8'h00, 8'h77});
    for (int i = 0; i < 4; i++) begin
      observe(1'b0, 0, 1'b1, 1'b0, o);
      if (i == 3) begin
        bus_a.cpu_req = 0;
        bus_a.dma_req = 0;
      end
      e = sb_q.pop_front();
      n_checks++;
      if (o.owner !== e.owner || o.addr !== e.addr) begin
        n_errors++;
        $display("FAIL tie_owner[%0d]: owner=%b addr=%h required %b/%h", i, o.owner, o.addr, e.owner, e.addr);
      end
      n_checks++;
      if (o.ads_cyc != ((i == 0) ? 1 : 2) || o.ack_cyc != ((i == 0) ? 3 : 4) || o.rdata !== e.rdata) begin
        n_errors++;
        $display("FAIL tie_timing[%0d]: ads=%0d ack=%0d rdata=%h required %0d/%0d/%h", i, o.ads_cyc, o.ack_cyc,
                 o.rdata, (i == 0) ? 1 : 2, (i == 0) ? 3 : 4, e.rdata);
      end
    end
    m_rdata_a = 8'h77;
    idle(25);  // let the slower instance drain
  endtask

  task automatic test_wait_min();
    obs_t o; exp_t e;
    bus_a.mem_d_i = 8'h3C;
    bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 12'h345;
    sb_q.push_back('{OWN_CPU, 12'h345, 1'b0, 8'h00, 8'h3C});
    m_rdata_a = 8'h3C;  // the WAIT_MIN=1 instance completes the same read
    observe(1'b1, 3, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_checks++;
    if (o.ads_cyc != 1 || o.strb_cnt != 4 || o.ack_cyc != 6) begin
      n_errors++;
      $display("FAIL wait_min_strobe: ads=%0d strb=%0d ack=%0d required 1/4/6", o.ads_cyc, o.strb_cnt, o.ack_cyc);
    end
    n_checks++;
    if (o.addr !== e.addr || o.rdata !== e.rdata || o.owner !== e.owner) begin
      n_errors++;
      $display("FAIL wait_min_data: addr=%h rdata=%h owner=%b required %h/%h/%b", o.addr, o.rdata, o.owner, e.addr, e.rdata, e.owner);
    end
    idle(12);
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    bit in_strb, saw_ack;
    in_strb = 0;
    saw_ack = 0;
    bus_a.cpu_req = 1; bus_a.cpu_we = 1; bus_a.cpu_addr = 12'h456; bus_a.cpu_wdata = 8'h99;
    for (int k = 0; k < BUDGET && !in_strb; k++) begin
      @(negedge clk);
      if (!bus_a.mem_ads_n) bus_a.cpu_req = 0;
      if (!bus_a.mem_wr_n) in_strb = 1;
    end
    n_checks++;
    if (!in_strb) begin
      n_errors++; $display("FAIL reset_mid_reach: write strobe seen=%b required 1", in_strb);
    end
    rst_n = 1'b0;
    @(negedge clk);
    m_rdata_a = 8'h00;
    n_checks++;
    if ({bus_a.mem_ads_n, bus_a.mem_rd_n, bus_a.mem_wr_n, bus_a.cpu_ack} !== 4'b1110) begin
      n_errors++;
      $display("FAIL reset_mid_strobes: ads/rd/wr/ack=%b required 1110",
               {bus_a.mem_ads_n, bus_a.mem_rd_n, bus_a.mem_wr_n, bus_a.cpu_ack});
    end
    n_checks++;
    if (bus_a.mem_addr !== 12'h000 || bus_a.mem_d_o !== 8'h00 || bus_a.rdata !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_mid_bus: addr=%h d_o=%h rdata=%h required 000/00/00", bus_a.mem_addr, bus_a.mem_d_o, bus_a.rdata);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_a.cpu_ack) saw_ack = 1;
    end
    n_checks++;
    if (saw_ack) begin
      n_errors++; $display("FAIL reset_mid_noack: cpu_ack seen=%b required 0", saw_ack);
    end
    bus_a.cpu_req = 1; bus_a.cpu_we = 1; bus_a.cpu_addr = 12'h456; bus_a.cpu_wdata = 8'h99;
    sb_q.push_back('{OWN_CPU, 12'h456, 1'b1, 8'h99, m_rdata_a});
    observe(1'b0, 0, 1'b0, 1'b0, o);
    e = sb_q.pop_front();
    n_checks++;
    if (o.ads_cyc != 1 || o.ack_cyc != 3 || o.addr !== e.addr || o.dout !== e.wdata) begin
      n_errors++;
      $display("FAIL reset_mid_retry: ads=%0d ack=%0d addr=%h d_o=%h required 1/3/%h/%h", o.ads_cyc, o.ack_cyc,
               o.addr, o.dout, e.addr, e.wdata);
    end
    n_checks++;
    if (o.rdata !== e.rdata || o.owner !== e.owner) begin
      n_errors++; $display("FAIL reset_mid_rdata: rdata=%h owner=%b required %h/%b", o.rdata, o.owner, e.rdata, e.owner);
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write_hold();
    test_mid_change();
    test_back_to_back_tie();
    test_wait_min();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
